// File: rtl/vld_delay_line_if.sv
// Bundles the data, control and status signals of the valid/data delay line.
// The source side uses the master modport and the delay line uses the slave modport.
// When VLD_DELAY_OCC_CNT_EN is defined, the bundle also carries the occupancy count occ_cnt.
interface vld_delay_line_if #(
    parameter int DATA_WIDTH = 256,
    parameter int MAX_DEPTH  = 16,
    parameter int DSEL_W     = $clog2(MAX_DEPTH + 1)
);
    logic [DSEL_W-1:0]     cfg_delay;
    logic                  stall;
    logic                  flush;
    logic                  vld_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  vld_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DSEL_W-1:0]     cur_delay;
    logic                  cfg_err;
`ifdef VLD_DELAY_OCC_CNT_EN
    logic [DSEL_W-1:0]     occ_cnt;

    modport master (
        output cfg_delay, stall, flush, vld_in, data_in,
        input  vld_out, data_out, cur_delay, cfg_err, occ_cnt
    );

    modport slave (
        input  cfg_delay, stall, flush, vld_in, data_in,
        output vld_out, data_out, cur_delay, cfg_err, occ_cnt
    );
`else
    modport master (
        output cfg_delay, stall, flush, vld_in, data_in,
        input  vld_out, data_out, cur_delay, cfg_err
    );

    modport slave (
        input  cfg_delay, stall, flush, vld_in, data_in,
        output vld_out, data_out, cur_delay, cfg_err
    );
`endif
endinterface

// File: rtl/vld_delay_line.sv
// Delays a valid-tagged data word by a runtime-programmable number of cycles (1..MAX_DEPTH).
// The chain supports stall, flush and valid-gated data stages.
// The delay can be reconfigured only while the observable part of the chain is empty,
// so no in-flight item is lost or duplicated.
// Optional macro VLD_DELAY_OCC_CNT_EN adds a registered occupancy count output (occ_cnt).
module vld_delay_line #(
    parameter int DATA_WIDTH = 256,
    parameter int MAX_DEPTH  = 16,
    parameter int DEF_DEPTH  = 16,
    parameter int DSEL_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    vld_delay_line_if.slave dl_io
);
    localparam logic [DSEL_W-1:0] MAX_SEL = DSEL_W'(MAX_DEPTH);
    localparam logic [DSEL_W-1:0] DEF_SEL = DSEL_W'(DEF_DEPTH);

    logic [MAX_DEPTH-1:0]  vld_q;
    logic [MAX_DEPTH-1:0]  vld_d;
    logic [DATA_WIDTH-1:0] dat_q [MAX_DEPTH];
    logic [DATA_WIDTH-1:0] dat_d [MAX_DEPTH];
    logic [DSEL_W-1:0]     cur_delay_q;
    logic [DSEL_W-1:0]     cur_delay_d;
    logic                  cfg_err_q;
    logic                  cfg_err_d;

    logic                  chain_empty;
    logic                  load_cfg;
    logic                  cfg_bad;
    logic [DSEL_W-1:0]     cfg_eff;
    logic [DSEL_W-1:0]     tap_sel;
    logic                  vld_tap;
    logic [DATA_WIDTH-1:0] dat_tap;

    assign tap_sel  = cur_delay_q - DSEL_W'(1);
    assign cfg_bad  = (dl_io.cfg_delay == '0) || (dl_io.cfg_delay > MAX_SEL);
    assign cfg_eff  = cfg_bad ? MAX_SEL : dl_io.cfg_delay;
    assign load_cfg = dl_io.flush || (chain_empty && !dl_io.stall);

    // The chain is empty when no valid sits in the stages up to and including the active tap.
    always_comb begin
        chain_empty = 1'b1;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if ((DSEL_W'(i) < cur_delay_q) && vld_q[i]) begin
                chain_empty = 1'b0;
            end
        end
    end

    // The tap mux selects the stage at cur_delay-1 as the visible output.
    always_comb begin
        vld_tap = 1'b0;
        dat_tap = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (DSEL_W'(i) == tap_sel) begin
                vld_tap = vld_q[i];
                dat_tap = dat_q[i];
            end
        end
    end

    // Shift the valids and move data only behind a valid.
    // On a reconfiguration edge, stale valids beyond the old tap are dropped
    // so they cannot reappear under a longer delay.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (dl_io.flush) begin
            vld_d = '0;
        end else if (!dl_io.stall) begin
            vld_d[0] = dl_io.vld_in;
            if (dl_io.vld_in) begin
                dat_d[0] = dl_io.data_in;
            end
            for (int i = 1; i < MAX_DEPTH; i++) begin
                vld_d[i] = load_cfg ? 1'b0 : vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                end
            end
        end
    end

    // The delay and error flag change only on load edges (idle-and-advancing, or flush).
    always_comb begin
        cur_delay_d = cur_delay_q;
        cfg_err_d   = cfg_err_q;
        if (load_cfg) begin
            cur_delay_d = cfg_eff;
            cfg_err_d   = cfg_bad;
        end
    end

    // Stage and configuration registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                dat_q[i] <= '0;
            end
            cur_delay_q <= DEF_SEL;
            cfg_err_q   <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            dat_q       <= dat_d;
            cur_delay_q <= cur_delay_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign dl_io.vld_out   = vld_tap;
    assign dl_io.data_out  = dat_tap;
    assign dl_io.cur_delay = cur_delay_q;
    assign dl_io.cfg_err   = cfg_err_q;

`ifdef VLD_DELAY_OCC_CNT_EN
    logic [DSEL_W-1:0] occ_q;
    logic [DSEL_W-1:0] occ_d;

    // Count items accepted but not yet emitted; a simultaneous accept and emit cancel out.
    always_comb begin
        occ_d = occ_q;
        if (dl_io.flush) begin
            occ_d = '0;
        end else if (!dl_io.stall) begin
            if (dl_io.vld_in && !vld_tap) begin
                occ_d = occ_q + DSEL_W'(1);
            end else if (!dl_io.vld_in && vld_tap) begin
                occ_d = occ_q - DSEL_W'(1);
            end
        end
    end

    // Occupancy register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign dl_io.occ_cnt = occ_q;
`endif
endmodule

// File: tb/tb_vld_delay_line.sv
// Testbench for vld_delay_line: directed scenarios followed by random traffic.
// A reference model tracks in-flight items by age and the active delay.
// A scoreboard queue of accepted words is drained by an output monitor.
module tb_vld_delay_line;
    localparam int DW   = 32;
    localparam int MAXD = 16;
    localparam int DEFD = 16;
    localparam int SW   = $clog2(MAXD + 1);

    typedef struct {
        logic [DW-1:0] data;
        int            age;
    } item_t;

    logic clk;
    logic rst_n;

    vld_delay_line_if #(.DATA_WIDTH(DW), .MAX_DEPTH(MAXD), .DSEL_W(SW)) bus ();

    vld_delay_line #(
        .DATA_WIDTH (DW),
        .MAX_DEPTH  (MAXD),
        .DEF_DEPTH  (DEFD),
        .DSEL_W     (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dl_io (bus)
    );

    int            total;
    int            bad;
    item_t         flight[$];
    logic [DW-1:0] expQ[$];
    int            modelDelay;
    logic          modelErr;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared comparison helper that counts every check.
    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Return the model to its reset state.
    task automatic resetModel();
        flight.delete();
        expQ.delete();
        modelDelay = DEFD;
        modelErr   = 1'b0;
    endtask

    // Apply the range rule for a requested delay.
    task automatic modelLoad(input int cfg);
        if (cfg >= 1 && cfg <= MAXD) begin
            modelDelay = cfg;
            modelErr   = 1'b0;
        end else begin
            modelDelay = MAXD;
            modelErr   = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model at the clock edge.
    task automatic applyStimulus(input logic vin, input logic [DW-1:0] din, input logic st,
                                 input logic fl, input logic [SW-1:0] cfg);
        logic wasEmpty;
        bus.vld_in    = vin;
        bus.data_in   = din;
        bus.stall     = st;
        bus.flush     = fl;
        bus.cfg_delay = cfg;
        @(posedge clk);
        if (rst_n) begin
            if (fl) begin
                for (int k = 0; k < flight.size(); k++) begin
                    if (expQ.size() > 0) void'(expQ.pop_back());
                end
                flight.delete();
                modelLoad(int'(cfg));
            end else if (!st) begin
                wasEmpty = (flight.size() == 0);
                if (flight.size() > 0 && flight[0].age == modelDelay) void'(flight.pop_front());
                foreach (flight[k]) flight[k].age++;
                if (vin) begin
                    flight.push_back('{data: din, age: 1});
                    expQ.push_back(din);
                end
                if (wasEmpty) modelLoad(int'(cfg));
            end
        end
        #1;
    endtask

    // Output monitor: check the status outputs each cycle and pop words as they are consumed.
    always @(negedge clk) begin
        logic          expVld;
        logic [DW-1:0] expData;
        if (rst_n) begin
            expVld = (flight.size() > 0) && (flight[0].age == modelDelay);
            checkOutput("vld_out", longint'(bus.vld_out), longint'(expVld));
            checkOutput("cur_delay", longint'(bus.cur_delay), longint'(modelDelay));
            checkOutput("cfg_err", longint'(bus.cfg_err), longint'(modelErr));
`ifdef VLD_DELAY_OCC_CNT_EN
            checkOutput("occ_cnt", longint'(bus.occ_cnt), longint'(flight.size()));
`endif
            if (bus.vld_out && !bus.stall && !bus.flush) begin
                if (expQ.size() == 0) begin
                    checkOutput("vld_out_without_item", longint'(bus.vld_out), 0);
                end else begin
                    expData = expQ.pop_front();
                    checkOutput("data_out", longint'(bus.data_out), longint'(expData));
                end
            end
        end
    end

    // Main sequence: reset, directed scenarios, mid-stream reset, random traffic, drain.
    initial begin
        logic          rv;
        logic          rs;
        logic          rf;
        logic [SW-1:0] rc;
        int            drain;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.vld_in    = 1'b0;
        bus.data_in   = '0;
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.cfg_delay = SW'(4);
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_vld_out", longint'(bus.vld_out), 0);
        checkOutput("reset_cur_delay", longint'(bus.cur_delay), DEFD);
        checkOutput("reset_cfg_err", longint'(bus.cfg_err), 0);
`ifdef VLD_DELAY_OCC_CNT_EN
        checkOutput("reset_occ_cnt", longint'(bus.occ_cnt), 0);
`endif
        rst_n = 1'b1;

        // Single pulse with delay 4.
        repeat (9) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(4));
        applyStimulus(1'b1, DW'('hA5), 1'b0, 1'b0, SW'(4));
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(4));

        // Continuous stream of 1..8 with delay 3 and a two-cycle stall.
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(3));
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) repeat (2) applyStimulus(1'b1, DW'(k), 1'b1, 1'b0, SW'(3));
            applyStimulus(1'b1, DW'(k), 1'b0, 1'b0, SW'(3));
        end
        repeat (6) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(3));

        // Three items at delay 6, flushed together with a stall, then a fresh item.
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(6));
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(32'h100 + k), 1'b0, 1'b0, SW'(6));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(6));
        applyStimulus(1'b1, DW'(32'hDEAD), 1'b1, 1'b1, SW'(6));
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(6));
        applyStimulus(1'b1, DW'(32'h200), 1'b0, 1'b0, SW'(6));
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(6));

        // Reconfigure from 5 to 2 while items are in flight.
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(5));
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(32'h300 + k), 1'b0, 1'b0, SW'(5));
        repeat (9) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(2));
        applyStimulus(1'b1, DW'(32'h3FF), 1'b0, 1'b0, SW'(2));
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(2));

        // Out-of-range requests clamp to the maximum; an in-range request clears the error.
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(0));
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(20));
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(7));

        // Burst of three at delay 4, then a mid-stream asynchronous reset.
        repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(4));
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(32'h400 + k), 1'b0, 1'b0, SW'(4));
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b0, SW'(4));
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, DW'(32'h500 + k), 1'b0, 1'b0, SW'(4));
        bus.vld_in = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_vld_out", longint'(bus.vld_out), 0);
        checkOutput("midreset_cur_delay", longint'(bus.cur_delay), DEFD);
`ifdef VLD_DELAY_OCC_CNT_EN
        checkOutput("midreset_occ_cnt", longint'(bus.occ_cnt), 0);
`endif
        resetModel();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic with stalls, flushes and reconfiguration requests.
        rc = SW'(3);
        for (int n = 0; n < 1500; n++) begin
            rv = ($urandom_range(0, 9) < 6);
            rs = ($urandom_range(0, 9) == 0);
            rf = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0) rc = SW'($urandom_range(0, 20));
            applyStimulus(rv, DW'($urandom), rs, rf, rc);
        end

        // Drain the remaining items with a bounded number of idle cycles.
        drain = 0;
        while (expQ.size() > 0 && drain < 40) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, rc);
            drain++;
        end
        checkOutput("drain_queue_size", longint'(expQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
